control_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 67 ++++++
 rtl/control_sequencer_if.sv | 49 ++++
 rtl/microcode_decoder.sv | 113 +++++++++++
 rtl/control_sequencer.sv | 116 +++++++++++
 tb/tb_control_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit CPU control path: opcode values, T-state
// encodings, default instruction/opcode widths and the control-word layout
// used between the microcode decoder and the sequencer.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int IW_DEFAULT  = 8;
    localparam int OPW_DEFAULT = 4;

    // Opcodes (upper nibble of the instruction register)
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // T-state encodings; 5 and 6 are never entered
    typedef enum logic [2:0] {
        T0     = 3'd0,
        T1     = 3'd1,
        T2     = 3'd2,
        T3     = 3'd3,
        T4     = 3'd4,
        T_HALT = 3'd7
    } tstate_t;

    // Control-word bit positions
    localparam int CW_PC_OUT     = 0;
    localparam int CW_PC_INC     = 1;
    localparam int CW_PC_LOAD    = 2;
    localparam int CW_MAR_LOAD   = 3;
    localparam int CW_RAM_OUT    = 4;
    localparam int CW_RAM_WRITE  = 5;
    localparam int CW_IR_LOAD    = 6;
    localparam int CW_IR_OUT     = 7;
    localparam int CW_A_LOAD     = 8;
    localparam int CW_A_OUT      = 9;
    localparam int CW_B_LOAD     = 10;
    localparam int CW_ALU_OUT    = 11;
    localparam int CW_ALU_SUB    = 12;
    localparam int CW_FLAGS_LOAD = 13;
    localparam int CW_OUT_LOAD   = 14;
    localparam int CW_W          = 15;

    typedef logic [CW_W-1:0] ctrl_word_t;

    function automatic ctrl_word_t cw_mask(input int idx);
        return ctrl_word_t'(1) << idx;
    endfunction

    // Strobes that change register/RAM state; these are the ones a
    // single-step debugger must be able to hold off.
    localparam ctrl_word_t LOAD_MASK =
        cw_mask(CW_PC_INC)   | cw_mask(CW_PC_LOAD) | cw_mask(CW_MAR_LOAD) |
        cw_mask(CW_RAM_WRITE) | cw_mask(CW_IR_LOAD) | cw_mask(CW_A_LOAD)   |
        cw_mask(CW_B_LOAD)   | cw_mask(CW_FLAGS_LOAD) | cw_mask(CW_OUT_LOAD);

endpackage

// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
// Bundle between the microsequencer and the CPU datapath.
//   master (sequencer): reads ir_q, carry_flag, zero_flag; drives every
//                       control strobe, halted and the debug tstate.
//   slave  (datapath):  the mirror image.
// -----------------------------------------------------------------------------
interface control_sequencer_if
    import cpu_pkg::*;
#(
    parameter int IW = IW_DEFAULT
);
    logic [IW-1:0] ir_q;
    logic          carry_flag;
    logic          zero_flag;

    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_write;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic flags_load;
    logic out_load;
    logic halted;
    logic [2:0] tstate;

    modport master (
        input  ir_q, carry_flag, zero_flag,
        output pc_out, pc_inc, pc_load, mar_load, ram_out, ram_write,
               ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub,
               flags_load, out_load, halted, tstate
    );

    modport slave (
        output ir_q, carry_flag, zero_flag,
        input  pc_out, pc_inc, pc_load, mar_load, ram_out, ram_write,
               ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub,
               flags_load, out_load, halted, tstate
    );

endinterface

// File: rtl/microcode_decoder.sv
// -----------------------------------------------------------------------------
// microcode_decoder
// Purely combinational microcode ROM: maps {opcode, tstate, flags} to the
// control word for the current cycle, plus done (instruction finishes at the
// end of this cycle) and halt_req (enter HALT at the end of this cycle).
// Ports:
//   opcode     in  OPW  opcode field of the IR (only meaningful in T2..T4)
//   tstate     in  3    current T-state
//   carry_flag in  1    registered carry, used by JC
//   zero_flag  in  1    registered zero, used by JZ
//   cw         out CW_W control word (bit layout in cpu_pkg)
//   done       out 1    last micro-step of the instruction
//   halt_req   out 1    HLT decoded in T2
// -----------------------------------------------------------------------------
module microcode_decoder
    import cpu_pkg::*;
#(
    parameter int OPW = OPW_DEFAULT
)(
    input  logic [OPW-1:0] opcode,
    input  tstate_t        tstate,
    input  logic           carry_flag,
    input  logic           zero_flag,
    output ctrl_word_t     cw,
    output logic           done,
    output logic           halt_req
);

    localparam ctrl_word_t M_PC_OUT     = cw_mask(CW_PC_OUT);
    localparam ctrl_word_t M_PC_INC     = cw_mask(CW_PC_INC);
    localparam ctrl_word_t M_PC_LOAD    = cw_mask(CW_PC_LOAD);
    localparam ctrl_word_t M_MAR_LOAD   = cw_mask(CW_MAR_LOAD);
    localparam ctrl_word_t M_RAM_OUT    = cw_mask(CW_RAM_OUT);
    localparam ctrl_word_t M_RAM_WRITE  = cw_mask(CW_RAM_WRITE);
    localparam ctrl_word_t M_IR_LOAD    = cw_mask(CW_IR_LOAD);
    localparam ctrl_word_t M_IR_OUT     = cw_mask(CW_IR_OUT);
    localparam ctrl_word_t M_A_LOAD     = cw_mask(CW_A_LOAD);
    localparam ctrl_word_t M_A_OUT      = cw_mask(CW_A_OUT);
    localparam ctrl_word_t M_B_LOAD     = cw_mask(CW_B_LOAD);
    localparam ctrl_word_t M_ALU_OUT    = cw_mask(CW_ALU_OUT);
    localparam ctrl_word_t M_ALU_SUB    = cw_mask(CW_ALU_SUB);
    localparam ctrl_word_t M_FLAGS_LOAD = cw_mask(CW_FLAGS_LOAD);
    localparam ctrl_word_t M_OUT_LOAD   = cw_mask(CW_OUT_LOAD);

    always_comb begin
        cw       = '0;
        done     = 1'b0;
        halt_req = 1'b0;

        case (tstate)
            T0: cw = M_PC_OUT | M_MAR_LOAD;
            T1: cw = M_RAM_OUT | M_IR_LOAD | M_PC_INC;

            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: cw = M_IR_OUT | M_MAR_LOAD;
                    OP_LDI: begin
                        cw   = M_IR_OUT | M_A_LOAD;
                        done = 1'b1;
                    end
                    OP_JMP: begin
                        cw   = M_IR_OUT | M_PC_LOAD;
                        done = 1'b1;
                    end
                    // Conditional jumps always drive the target; only the
                    // PC load depends on the flag.
                    OP_JC: begin
                        cw   = M_IR_OUT | (carry_flag ? M_PC_LOAD : '0);
                        done = 1'b1;
                    end
                    OP_JZ: begin
                        cw   = M_IR_OUT | (zero_flag ? M_PC_LOAD : '0);
                        done = 1'b1;
                    end
                    OP_OUT: begin
                        cw   = M_A_OUT | M_OUT_LOAD;
                        done = 1'b1;
                    end
                    OP_HLT:  halt_req = 1'b1;
                    default: done = 1'b1;
                endcase
            end

            T3: begin
                case (opcode)
                    OP_LDA: begin
                        cw   = M_RAM_OUT | M_A_LOAD;
                        done = 1'b1;
                    end
                    OP_ADD, OP_SUB: cw = M_RAM_OUT | M_B_LOAD;
                    OP_STA: begin
                        cw   = M_A_OUT | M_RAM_WRITE;
                        done = 1'b1;
                    end
                    // Reached only if ir_q changed mid-instruction: bail out.
                    default: done = 1'b1;
                endcase
            end

            T4: begin
                done = 1'b1;
                case (opcode)
                    OP_ADD: cw = M_ALU_OUT | M_A_LOAD | M_FLAGS_LOAD;
                    OP_SUB: cw = M_ALU_OUT | M_A_LOAD | M_FLAGS_LOAD | M_ALU_SUB;
                    default: cw = '0;
                endcase
            end

            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Microsequencer FSM for the 8-bit CPU. Steps T0..T4, ends each instruction
// as soon as its last micro-step has run, and parks in HALT on HLT until rst.
// Ports:
//   clk   in  1  positive-edge clock
//   rst   in  1  asynchronous active-high reset; also forces every control
//                output and halted low while high
//   step  in  1  (only with SINGLE_STEP_EN) advance enable, one clk wide
//   bus   control_sequencer_if.master: ir_q/flags in, strobes/halted/tstate out
// Build option: define SINGLE_STEP_EN to add the step input; otherwise the
// FSM advances on every clk edge.
// -----------------------------------------------------------------------------
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int IW  = IW_DEFAULT,
    parameter int OPW = OPW_DEFAULT
)(
    input  logic clk,
    input  logic rst,
`ifdef SINGLE_STEP_EN
    input  logic step,
`endif
    control_sequencer_if.master bus
);

    tstate_t         state;
    tstate_t         next_state;
    logic [OPW-1:0]  opcode;
    ctrl_word_t      cw;
    ctrl_word_t      gate_mask;
    ctrl_word_t      cw_live;
    logic            done;
    logic            halt_req;
    logic            advance;
    logic            unused_operand;

    assign opcode = bus.ir_q[IW-1:IW-OPW];
    // Operand bits are routed to the bus by the IR itself, not by us.
    assign unused_operand = ^bus.ir_q[IW-OPW-1:0];

    microcode_decoder #(
        .OPW(OPW)
    ) u_decoder (
        .opcode    (opcode),
        .tstate    (state),
        .carry_flag(bus.carry_flag),
        .zero_flag (bus.zero_flag),
        .cw        (cw),
        .done      (done),
        .halt_req  (halt_req)
    );

`ifdef SINGLE_STEP_EN
    assign advance   = step;
    // Bus drivers stay live so the stalled cycle can be inspected; only
    // state-changing strobes wait for the step pulse.
    assign gate_mask = step ? '1 : ~LOAD_MASK;
`else
    assign advance   = 1'b1;
    assign gate_mask = '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= T0;
        end else if (advance) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            T0:     next_state = T1;
            T1:     next_state = T2;
            T2, T3: begin
                if (halt_req) begin
                    next_state = T_HALT;
                end else if (done) begin
                    next_state = T0;
                end else begin
                    next_state = tstate_t'(state + 3'd1);
                end
            end
            T4:     next_state = T0;
            T_HALT: next_state = T_HALT;
            default: next_state = T0;   // 5/6 recover to fetch
        endcase
    end

    // rst gates outputs combinationally so nothing strobes before the
    // asynchronous state reset has propagated.
    assign cw_live = cw & gate_mask & {CW_W{~rst}};

    assign bus.pc_out     = cw_live[CW_PC_OUT];
    assign bus.pc_inc     = cw_live[CW_PC_INC];
    assign bus.pc_load    = cw_live[CW_PC_LOAD];
    assign bus.mar_load   = cw_live[CW_MAR_LOAD];
    assign bus.ram_out    = cw_live[CW_RAM_OUT];
    assign bus.ram_write  = cw_live[CW_RAM_WRITE];
    assign bus.ir_load    = cw_live[CW_IR_LOAD];
    assign bus.ir_out     = cw_live[CW_IR_OUT];
    assign bus.a_load     = cw_live[CW_A_LOAD];
    assign bus.a_out      = cw_live[CW_A_OUT];
    assign bus.b_load     = cw_live[CW_B_LOAD];
    assign bus.alu_out    = cw_live[CW_ALU_OUT];
    assign bus.alu_sub    = cw_live[CW_ALU_SUB];
    assign bus.flags_load = cw_live[CW_FLAGS_LOAD];
    assign bus.out_load   = cw_live[CW_OUT_LOAD];

    assign bus.halted = (state == T_HALT) & ~rst;
    assign bus.tstate = state;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Self-checking bench for control_sequencer. A per-opcode micro-step table
// predicts every cycle's strobes; directed checks pin literal values.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    localparam logic [14:0] PC_OUT     = 15'h4000;
    localparam logic [14:0] PC_INC     = 15'h2000;
    localparam logic [14:0] PC_LOAD    = 15'h1000;
    localparam logic [14:0] MAR_LOAD   = 15'h0800;
    localparam logic [14:0] RAM_OUT    = 15'h0400;
    localparam logic [14:0] RAM_WRITE  = 15'h0200;
    localparam logic [14:0] IR_LOAD    = 15'h0100;
    localparam logic [14:0] IR_OUT     = 15'h0080;
    localparam logic [14:0] A_LOAD     = 15'h0040;
    localparam logic [14:0] A_OUT      = 15'h0020;
    localparam logic [14:0] B_LOAD     = 15'h0010;
    localparam logic [14:0] ALU_OUT    = 15'h0008;
    localparam logic [14:0] ALU_SUB    = 15'h0004;
    localparam logic [14:0] FLAGS_LOAD = 15'h0002;
    localparam logic [14:0] OUT_LOAD   = 15'h0001;
    localparam logic [14:0] LOADS = PC_INC | PC_LOAD | MAR_LOAD | RAM_WRITE |
                                    IR_LOAD | A_LOAD | B_LOAD | FLAGS_LOAD | OUT_LOAD;
    localparam logic [14:0] BUSDRV = PC_OUT | RAM_OUT | IR_OUT | A_OUT | ALU_OUT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic adv;
`ifdef SINGLE_STEP_EN
    logic step = 1'b1;
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    control_sequencer_if #(.IW(8)) bus ();

    control_sequencer dut (
        .clk (clk),
        .rst (rst),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: instruction = list of micro-step words, length ulen.
    logic [14:0] ustep [16][5];
    int          ulen  [16];
    int          m_step   = 0;
    bit          m_halted = 1'b0;
    bit          sta_window = 1'b0;
    bit          wr_seen    = 1'b0;

    initial begin
        for (int op = 0; op < 16; op++) begin
            ulen[op] = 3;
            ustep[op][0] = PC_OUT | MAR_LOAD;
            ustep[op][1] = RAM_OUT | IR_LOAD | PC_INC;
            for (int k = 2; k < 5; k++) ustep[op][k] = '0;
        end
        ulen[1] = 4; ustep[1][2] = IR_OUT | MAR_LOAD; ustep[1][3] = RAM_OUT | A_LOAD;
        ulen[2] = 5; ustep[2][2] = IR_OUT | MAR_LOAD; ustep[2][3] = RAM_OUT | B_LOAD;
        ustep[2][4] = ALU_OUT | A_LOAD | FLAGS_LOAD;
        ulen[3] = 5; ustep[3][2] = IR_OUT | MAR_LOAD; ustep[3][3] = RAM_OUT | B_LOAD;
        ustep[3][4] = ALU_OUT | A_LOAD | FLAGS_LOAD | ALU_SUB;
        ulen[4] = 4; ustep[4][2] = IR_OUT | MAR_LOAD; ustep[4][3] = A_OUT | RAM_WRITE;
        ustep[5][2]  = IR_OUT | A_LOAD;
        ustep[6][2]  = IR_OUT | PC_LOAD;
        ustep[7][2]  = IR_OUT | PC_LOAD;
        ustep[8][2]  = IR_OUT | PC_LOAD;
        ustep[14][2] = A_OUT | OUT_LOAD;
        ulen[15] = 99;
    end

    function automatic logic [14:0] dut_word();
        return {bus.pc_out, bus.pc_inc, bus.pc_load, bus.mar_load, bus.ram_out,
                bus.ram_write, bus.ir_load, bus.ir_out, bus.a_load, bus.a_out,
                bus.b_load, bus.alu_out, bus.alu_sub, bus.flags_load, bus.out_load};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the active edge
    always @(posedge clk) begin
        if (rst) begin
            m_step   <= 0;
            m_halted <= 1'b0;
        end else if (!m_halted && adv) begin
            if (m_step == 2 && bus.ir_q[7:4] == 4'hF) m_halted <= 1'b1;
            else if (m_step + 1 >= ulen[bus.ir_q[7:4]]) m_step <= 0;
            else m_step <= m_step + 1;
        end
        if (sta_window && bus.ram_write) wr_seen <= 1'b1;
    end

    // Per-cycle compare on the opposite edge
    logic [14:0] e_word;
    logic [14:0] a_word;
    int          e_ts;
    logic        e_h;
    logic [3:0]  c_op;
    always @(negedge clk) begin
        c_op   = bus.ir_q[7:4];
        a_word = dut_word();
        if (rst) begin
            e_word = '0; e_ts = 0; e_h = 1'b0;
        end else if (m_halted) begin
            e_word = '0; e_ts = 7; e_h = 1'b1;
        end else begin
            e_word = ustep[c_op][m_step];
            if ((c_op == 4'h7 && !bus.carry_flag) || (c_op == 4'h8 && !bus.zero_flag))
                e_word = e_word & ~PC_LOAD;
`ifdef SINGLE_STEP_EN
            if (!step) e_word = e_word & ~LOADS;
`endif
            e_ts = m_step;
            e_h  = 1'b0;
        end
        check("ctrl_word", int'(a_word), int'(e_word));
        check("tstate", int'(bus.tstate), e_ts);
        check("halted", int'(bus.halted), int'(e_h));
        check("bus_exclusive", int'($countones(a_word & BUSDRV) <= 1), 1);
    end

    task automatic next_cyc();
        @(negedge clk);
        #2;
    endtask

    int explen [15] = '{3, 4, 5, 5, 4, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    int n;
    int ts0;
    int steps_exp [3] = '{2, 0, 1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ir_q = 8'h00;
        bus.carry_flag = 1'b0;
        bus.zero_flag  = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("reset_tstate", int'(bus.tstate), 0);
        check("reset_halted", int'(bus.halted), 0);
        check("reset_ctrl", int'(dut_word()), 0);

        // LDI 0x5A
        rst = 1'b0;
        bus.ir_q = 8'h5A;
        #1;
        check("ldi_t0", int'(dut_word()), 'h4800);
        next_cyc();
        check("ldi_t1", int'(dut_word()), 'h2500);
        next_cyc();
        check("ldi_t2", int'(dut_word()), 'h00C0);
        next_cyc();
        check("ldi_t3_is_t0", int'(bus.tstate), 0);

        // ADD then SUB
        bus.ir_q = 8'h2F;
        for (int i = 1; i <= 4; i++) begin
            next_cyc();
            check("add_tstate", int'(bus.tstate), i);
            check("add_alu_sub", int'(bus.alu_sub), 0);
            check("add_flags_load", int'(bus.flags_load), (i == 4) ? 1 : 0);
        end
        next_cyc();
        check("add_end", int'(bus.tstate), 0);
        bus.ir_q = 8'h3F;
        for (int i = 1; i <= 4; i++) begin
            next_cyc();
            check("sub_tstate", int'(bus.tstate), i);
            check("sub_alu_sub", int'(bus.alu_sub), (i == 4) ? 1 : 0);
            check("sub_flags_load", int'(bus.flags_load), (i == 4) ? 1 : 0);
        end
        next_cyc();
        check("sub_end", int'(bus.tstate), 0);

        // JC / JZ with flag low and high
        for (int j = 0; j < 4; j++) begin
            bus.ir_q       = (j < 2) ? 8'h73 : 8'h83;
            bus.carry_flag = (j == 1);
            bus.zero_flag  = (j == 3);
            next_cyc();
            next_cyc();
            check("jcc_pc_load", int'(bus.pc_load), j % 2);
            check("jcc_ir_out", int'(bus.ir_out), 1);
            next_cyc();
            check("jcc_len3", int'(bus.tstate), 0);
        end
        bus.carry_flag = 1'b0;
        bus.zero_flag  = 1'b0;

        // Every non-halting opcode: length, with bus exclusivity checked per cycle
        for (int op = 0; op < 15; op++) begin
            bus.ir_q = {op[3:0], 4'h3};
            n = 0;
            do begin
                next_cyc();
                n++;
            end while (bus.tstate != 3'd0 && n < 8);
            check("op_len", n, explen[op]);
        end

        // Reset during T3 of STA
        bus.ir_q   = 8'h4C;
        sta_window = 1'b1;
        next_cyc();
        next_cyc();
        @(posedge clk);
        #1;
        check("sta_in_t3", int'(bus.tstate), 3);
        rst = 1'b1;
        #1;
        check("sta_rst_ctrl", int'(dut_word()), 0);
        check("sta_rst_tstate", int'(bus.tstate), 0);
        next_cyc();
        next_cyc();
        bus.ir_q = 8'h00;
        rst = 1'b0;
        sta_window = 1'b0;
        check("sta_no_write_edge", int'(wr_seen), 0);

        // HLT
        bus.ir_q = 8'hF0;
        next_cyc();
        next_cyc();
        check("hlt_t2_not_halted", int'(bus.halted), 0);
        next_cyc();
        check("hlt_halted", int'(bus.halted), 1);
        check("hlt_tstate", int'(bus.tstate), 7);
        repeat (20) next_cyc();
        check("hlt_still_quiet", int'(dut_word()), 0);
        check("hlt_still_halted", int'(bus.halted), 1);
        rst = 1'b1;
        #1;
        check("hlt_rst_tstate", int'(bus.tstate), 0);
        check("hlt_rst_halted", int'(bus.halted), 0);
        bus.ir_q = 8'h00;
        next_cyc();
        rst = 1'b0;
        next_cyc();
        check("after_hlt_fetch", int'(bus.tstate), 1);

`ifdef SINGLE_STEP_EN
        step = 1'b0;
        ts0 = int'(bus.tstate);
        repeat (10) next_cyc();
        check("step_hold_tstate", int'(bus.tstate), ts0);
        check("step_hold_loads", int'(dut_word() & LOADS), 0);
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            next_cyc();
            step = 1'b0;
            check("step_pulse", int'(bus.tstate), steps_exp[p]);
        end
`else
        ts0 = 0;
        check("steps_table_unused", ts0 + steps_exp[0], 2);
`endif

        next_cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
